// File: rtl/lmx_pkg.sv
// Shared constants and FSM encoding for the LMX synthesizer SPI register loader.
package lmx_pkg;

    localparam int LMX_WORD_W    = 24;
    localparam int LMX_BIT_CNT_W = 5;
    localparam int LMX_DIV_CNT_W = 8;

    localparam logic [LMX_WORD_W-1:0] LMX_SOFT_RESET_ON  = 24'h00201E;
    localparam logic [LMX_WORD_W-1:0] LMX_SOFT_RESET_OFF = 24'h00201C;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        FETCH,
        SHIFT,
        GAP,
        FIN
    } lmx_state_e;

    function automatic logic is_last_bit(input logic [LMX_BIT_CNT_W-1:0] cnt);
        return cnt == LMX_BIT_CNT_W'(LMX_WORD_W - 1);
    endfunction

endpackage

// File: rtl/lmx_spi_loader_if.sv
// SPI pin bundle between the word shifter and the loader pins.
interface lmx_spi_loader_if;
    logic csb;
    logic sck;
    logic sdi;

    modport master (output csb, output sck, output sdi);
    modport slave  (input  csb, input  sck, input  sdi);
endinterface

// File: rtl/lmx_spi_shifter.sv
// One framed 24-bit SPI mode-0 transfer: CSB low, 24 SCK pulses MSB first, CSB high.
module lmx_spi_shifter
    import lmx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  load,
    input  logic [LMX_WORD_W-1:0] word,
    output logic                  busy,
    output logic                  done,
    lmx_spi_loader_if.master      spi
);

    localparam logic [LMX_DIV_CNT_W-1:0] DIV_LAST = LMX_DIV_CNT_W'(CLK_DIV - 1);

    logic [LMX_WORD_W-1:0]    shift_reg;
    logic [LMX_DIV_CNT_W-1:0] div_reg;
    logic [LMX_BIT_CNT_W-1:0] bit_reg;
    logic                     tail_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     csb_reg;
    logic                     sck_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_reg <= '0;
            div_reg   <= '0;
            bit_reg   <= '0;
            tail_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            csb_reg   <= 1'b1;
            sck_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load && !busy_reg) begin
                shift_reg <= word;
                div_reg   <= '0;
                bit_reg   <= '0;
                tail_reg  <= 1'b0;
                busy_reg  <= 1'b1;
                csb_reg   <= 1'b0;
                sck_reg   <= 1'b0;
            end else if (busy_reg) begin
                if (tail_reg) begin
                    // One clk of hold after the last falling edge, then release CSB.
                    csb_reg   <= 1'b1;
                    shift_reg <= '0;
                    tail_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end else if (div_reg == DIV_LAST) begin
                    div_reg <= '0;
                    if (!sck_reg) begin
                        sck_reg <= 1'b1;
                    end else begin
                        sck_reg <= 1'b0;
                        if (is_last_bit(bit_reg)) begin
                            tail_reg <= 1'b1;
                        end else begin
                            bit_reg   <= bit_reg + 1'b1;
                            shift_reg <= {shift_reg[LMX_WORD_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_reg <= div_reg + 1'b1;
                end
            end
        end
    end

    // SDI is the shifter MSB so it is registered and returns to 0 when the frame ends.
    assign spi.csb = csb_reg;
    assign spi.sck = sck_reg;
    assign spi.sdi = shift_reg[LMX_WORD_W-1];
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: rtl/lmx_spi_loader.sv
// Streams the LMX register table (indices 0..NUM_REGS-1) out over SPI on each start request.
// Define LMX_SOFT_RESET_EN to prefix every load with the RESET=1 / RESET=0 soft-reset words.
module lmx_spi_loader
    import lmx_pkg::*;
#(
    parameter int NUM_REGS = 126,
    parameter int CLK_DIV  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic [7:0]            o_reg_nr,
    input  logic [LMX_WORD_W-1:0] i_lmx_reg,
    output logic                  o_spi_csb,
    output logic                  o_spi_sck,
    output logic                  o_spi_sdi,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int               GAP_W    = $clog2(CS_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [7:0]       LAST_IDX = 8'(NUM_REGS - 1);

    lmx_state_e            state_reg;
    logic [7:0]            reg_nr_reg;
    logic [GAP_W-1:0]      gap_reg;
    logic                  busy_reg;
    logic                  done_reg;
    logic [LMX_WORD_W-1:0] fetch_word;
    logic                  pre_pending;
    logic                  sh_load;
    logic                  sh_busy;
    logic                  sh_done;

    lmx_spi_loader_if spi_bus ();

`ifdef LMX_SOFT_RESET_EN
    logic [1:0] pre_reg;
    logic       start_accept;
    logic       gap_end;

    assign start_accept = (state_reg == IDLE) && i_start;
    assign gap_end      = (state_reg == GAP) && (gap_reg == GAP_LAST);

    // pre_reg walks 0 -> 1 -> 2 across the two soft-reset frames; 2 means table words.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pre_reg <= 2'd0;
        end else if (start_accept) begin
            pre_reg <= 2'd0;
        end else if (gap_end && pre_reg != 2'd2) begin
            pre_reg <= pre_reg + 2'd1;
        end
    end

    assign pre_pending = (pre_reg != 2'd2);

    always_comb begin
        fetch_word = i_lmx_reg;
        if (pre_reg == 2'd0) begin
            fetch_word = LMX_SOFT_RESET_ON;
        end else if (pre_reg == 2'd1) begin
            fetch_word = LMX_SOFT_RESET_OFF;
        end
    end
`else
    assign pre_pending = 1'b0;
    assign fetch_word  = i_lmx_reg;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            reg_nr_reg <= '0;
            gap_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        busy_reg   <= 1'b1;
                        reg_nr_reg <= '0;
                        state_reg  <= ADDR;
                    end
                end
                ADDR: begin
                    state_reg <= FETCH;
                end
                FETCH: begin
                    state_reg <= SHIFT;
                end
                SHIFT: begin
                    if (sh_done) begin
                        gap_reg   <= '0;
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        if (pre_pending) begin
                            state_reg <= ADDR;
                        end else if (reg_nr_reg < LAST_IDX) begin
                            reg_nr_reg <= reg_nr_reg + 8'd1;
                            state_reg  <= ADDR;
                        end else begin
                            // done is raised on entry to FIN so a start in the pulse cycle is not seen in IDLE.
                            done_reg  <= 1'b1;
                            state_reg <= FIN;
                        end
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // The shifter captures the ROM word on the FETCH clock edge.
    assign sh_load = (state_reg == FETCH) && !sh_busy;

    lmx_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .load    (sh_load),
        .word    (fetch_word),
        .busy    (sh_busy),
        .done    (sh_done),
        .spi     (spi_bus)
    );

    assign o_spi_csb = spi_bus.csb;
    assign o_spi_sck = spi_bus.sck;
    assign o_spi_sdi = spi_bus.sdi;
    assign o_reg_nr  = reg_nr_reg;
    assign o_busy    = busy_reg;
    assign o_done    = done_reg;

endmodule

// File: tb/tb_lmx_spi_loader.sv
// Directed bench: decodes SPI frames from the pins and compares them with the expected load sequence.
module tb_lmx_spi_loader;

    localparam int NUM_REGS = 126;
    localparam int CLK_DIV  = 4;
    localparam int CS_GAP   = 8;
    localparam int S_NUM    = 3;
`ifdef LMX_SOFT_RESET_EN
    localparam int PRE = 2;
    localparam logic [23:0] FIRST_WORD = 24'h00201E;
`else
    localparam int PRE = 0;
    localparam logic [23:0] FIRST_WORD = 24'h7D2288;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [7:0]  reg_nr;
    logic [23:0] rom_q;
    logic        csb_w, sck_w, sdi_w, busy, done;

    logic        s_start;
    logic [7:0]  s_reg_nr;
    logic [23:0] s_rom_q;
    logic        s_csb, s_sck, s_sdi, s_busy, s_done;

    lmx_spi_loader_if spi ();
    assign spi.csb = csb_w;
    assign spi.sck = sck_w;
    assign spi.sdi = sdi_w;

    lmx_spi_loader #(.NUM_REGS(NUM_REGS), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_reg_nr(reg_nr), .i_lmx_reg(rom_q),
        .o_spi_csb(csb_w), .o_spi_sck(sck_w), .o_spi_sdi(sdi_w), .o_busy(busy), .o_done(done));

    lmx_spi_loader #(.NUM_REGS(S_NUM), .CLK_DIV(2), .CS_GAP(2)) dut_fast (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(s_start), .o_reg_nr(s_reg_nr), .i_lmx_reg(s_rom_q),
        .o_spi_csb(s_csb), .o_spi_sck(s_sck), .o_spi_sdi(s_sdi), .o_busy(s_busy), .o_done(s_done));

    // ---------------- model ----------------
    function automatic logic [23:0] rom_word(input int i);
        if (i == 0) return 24'h7D2288;
        if (i == NUM_REGS - 1) return 24'h00201C;
        return {8'(i), 8'(8'hA5 ^ i), 8'(i * 3 + 1)};
    endfunction

    function automatic logic [23:0] exp_word(input int k);
        if (k < PRE) return (k == 0) ? 24'h00201E : 24'h00201C;
        if (k - PRE >= NUM_REGS) return 24'hDEAD00;
        return rom_word(k - PRE);
    endfunction

    function automatic logic [7:0] exp_idx(input int k);
        return (k < PRE) ? 8'd0 : 8'(k - PRE);
    endfunction

    logic [23:0] rom [0:255];
    always @(posedge clk) begin
        rom_q   <= rom[reg_nr];
        s_rom_q <= rom[s_reg_nr];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- compare process for the main DUT ----------------
    int          frame_cnt = 0;
    int          bits = 0;
    int          hi_cnt = 0;
    int          done_cnt = 0;
    logic [23:0] sh = '0;
    logic [23:0] first_frame = '0;
    logic [23:0] last_frame = '0;
    logic        p_csb = 1'b1, p_sck = 1'b0, p_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bits = 0; hi_cnt = 0;
            p_csb = 1'b1; p_sck = 1'b0; p_done = 1'b0;
        end else begin
            if (spi.csb) check("sck_idle_low", {31'd0, spi.sck}, 32'd0);
            check("reg_nr_bound", {31'd0, reg_nr <= 8'(NUM_REGS - 1)}, 32'd1);
            if (p_csb && !spi.csb) begin
                bits = 0;
                check("reg_nr_at_frame", {24'd0, reg_nr}, {24'd0, exp_idx(frame_cnt)});
                check("busy_in_frame", {31'd0, busy}, 32'd1);
            end
            if (spi.sck && !p_sck) begin
                sh = {sh[22:0], spi.sdi};
                bits++;
                hi_cnt = 1;
            end else if (spi.sck) begin
                hi_cnt++;
            end
            if (p_sck && !spi.sck) check("sck_high_time", hi_cnt, CLK_DIV);
            if (!p_csb && spi.csb) begin
                check("frame_bits", bits, 24);
                check("frame_data", {8'd0, sh}, {8'd0, exp_word(frame_cnt)});
                if (frame_cnt == 0) first_frame = sh;
                last_frame = sh;
                frame_cnt++;
            end
            if (done) begin
                check("done_one_cycle", {31'd0, p_done}, 32'd0);
                done_cnt++;
            end
            p_csb = spi.csb; p_sck = spi.sck; p_done = done;
        end
    end

    // ---------------- timing monitor for the CLK_DIV=2 / CS_GAP=2 instance ----------------
    int   s_frames = 0, s_since = 0, s_rises = 0, s_hi = 0;
    logic s_p_csb = 1'b1, s_p_sck = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            s_p_csb = 1'b1; s_p_sck = 1'b0; s_hi = 0;
        end else begin
            if (!s_csb && s_p_csb) begin
                if (s_frames > 0) check("fast_csb_gap", {31'd0, s_hi >= 2}, 32'd1);
                s_rises = 0;
            end
            if (s_sck && !s_p_sck) begin
                if (s_rises > 0) check("fast_sck_period", s_since, 4);
                s_since = 0;
                s_rises++;
            end
            s_since++;
            if (s_csb && !s_p_csb) begin
                check("fast_pulses", s_rises, 24);
                s_frames++;
                s_hi = 0;
            end
            if (s_csb) s_hi++;
            s_p_csb = s_csb; s_p_sck = s_sck;
        end
    end

    task automatic wait_frames(input int n, input int limit);
        int c = 0;
        while (frame_cnt < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("wait_frames", {31'd0, frame_cnt >= n}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        rst_n = 1'b0; start = 1'b0; s_start = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = rom_word(i);
        repeat (3) @(negedge clk);
        check("rst_csb", {31'd0, csb_w}, 32'd1);
        check("rst_sck", {31'd0, sck_w}, 32'd0);
        check("rst_sdi", {31'd0, sdi_w}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_reg_nr", {24'd0, reg_nr}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fast instance: short load, timing checked by its monitor.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        c = 0;
        while (!s_done && c < 5000) begin @(negedge clk); c++; end
        check("fast_done_seen", {31'd0, s_done}, 32'd1);
        @(negedge clk);
        check("fast_frames", s_frames, S_NUM + PRE);
        check("fast_busy_after", {31'd0, s_busy}, 32'd0);

        // Full load with extra start requests while busy.
        frame_cnt = 0; done_cnt = 0;
        pulse_start();
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_frames(3, 2000);
        pulse_start();
        wait_frames(60, 20000);
        pulse_start();
        c = 0;
        while (!done && c < 40000) begin @(negedge clk); c++; end
        check("done_seen", {31'd0, done}, 32'd1);
        pulse_start();  // coincident with the done pulse: must be ignored
        check("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (400) @(negedge clk);
        check("frame_count", frame_cnt, NUM_REGS + PRE);
        check("done_count", done_cnt, 1);
        check("no_restart", {31'd0, busy}, 32'd0);
        check("first_frame", {8'd0, first_frame}, {8'd0, FIRST_WORD});
        check("last_frame", {8'd0, last_frame}, 32'h0000201C);
        check("reg_nr_hold", {24'd0, reg_nr}, NUM_REGS - 1);

        // Reset in the middle of word 5, then restart from index 0.
        frame_cnt = 0;
        pulse_start();
        wait_frames(PRE + 5, 5000);
        c = 0;
        while (bits < 10 && c < 2000) begin @(negedge clk); c++; end
        check("reached_bit10", {31'd0, bits >= 10}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_csb", {31'd0, csb_w}, 32'd1);
        check("midrst_sck", {31'd0, sck_w}, 32'd0);
        check("midrst_sdi", {31'd0, sdi_w}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_reg_nr", {24'd0, reg_nr}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frame_cnt = 0;
        pulse_start();
        wait_frames(PRE + 2, 3000);
        check("restart_first", {8'd0, first_frame}, {8'd0, FIRST_WORD});
        check("restart_busy", {31'd0, busy}, 32'd1);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
